// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_LEN_W = 8;

  // Arbiter FSM states, encoded in order so a debug probe reads 0..5.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner
// and wraps, so the previous owner is considered last.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk candidates last+1 .. last+N_REQ (mod N_REQ) and keep the first hit.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last_i) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ packet sources.
// Handshake: a source holds req high (with req_len stable until grant) until it
// sees its one-cycle done pulse; bytes are pulled with a one-cycle byte_rd
// strobe and rd_data must be valid the following cycle; each byte is handed to
// the UART with a one-cycle write_en and the next byte waits for the falling
// edge of tx_busy.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*8-1:0]     rd_data,
  input  logic                   tx_busy,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       byte_rd,
  output logic [LEN_W-1:0]       byte_idx,
  output logic [N_REQ-1:0]       done,
  output logic [7:0]             write_data,
  output logic                   write_en,
  output state_e                 dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] byte_rd_q;
  logic [LEN_W-1:0] byte_idx_q;
  logic [LEN_W-1:0] byte_idx_d;
  logic [N_REQ-1:0] done_q;
  logic [7:0]       wdata_q;
  logic             wen_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] win_q;
  logic [LEN_W-1:0] len_q;
  logic             busy_dly_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [LEN_W-1:0] sel_len;
  logic [7:0]       sel_rd;
  logic             busy_fall;
  logic             last_byte;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign sel_len    = req_len[int'(pick_idx)*LEN_W +: LEN_W];
  assign sel_rd     = rd_data[int'(win_q)*8 +: 8];
  assign busy_fall  = busy_dly_q & ~tx_busy;
  assign last_byte  = (byte_idx_q == (len_q - 1'b1));
  assign byte_idx_d = byte_idx_q + 1'b1;

  // Delayed copy of tx_busy for falling-edge detection; only WAIT looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_dly_q <= 1'b0;
    else        busy_dly_q <= tx_busy;
  end

  // Packet FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      byte_rd_q  <= '0;
      byte_idx_q <= '0;
      done_q     <= '0;
      wdata_q    <= 8'h00;
      wen_q      <= 1'b0;
      last_q     <= IDX_W'(N_REQ - 1);
      win_q      <= '0;
      len_q      <= '0;
    end else begin
      byte_rd_q <= '0;
      wen_q     <= 1'b0;
      done_q    <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_gnt;
            win_q      <= pick_idx;
            len_q      <= sel_len;
            byte_idx_q <= '0;
            // An empty packet is acknowledged without touching the source or UART.
            if (sel_len == '0) begin
              state_q <= DONE;
            end else begin
              byte_rd_q <= pick_gnt;
              state_q   <= FETCH;
            end
          end
        end
        FETCH: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          wdata_q <= sel_rd;
          wen_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (busy_fall) begin
            if (last_byte) begin
              state_q <= DONE;
            end else begin
              byte_idx_q <= byte_idx_d;
              byte_rd_q  <= grant_q;
              state_q    <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= grant_q;
          last_q  <= win_q;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign byte_rd    = byte_rd_q;
  assign byte_idx   = byte_idx_q;
  assign done       = done_q;
  assign write_data = wdata_q;
  assign write_en   = wen_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with source/UART models and a scoreboard.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N_REQ    = 4;
  localparam int LEN_W    = 8;
  localparam int BUSY_CYC = 20;
  localparam int EW       = N_REQ + 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ*8-1:0]     rd_data = '0;
  logic                   tx_busy = 1'b0;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       byte_rd;
  logic [LEN_W-1:0]       byte_idx;
  logic [N_REQ-1:0]       done;
  logic [7:0]             write_data;
  logic                   write_en;
  state_e                 dbg_state;

  logic uart_en;
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr     = 0;
  int   n_rd     = 0;
  int   n_done   = 0;

  logic [EW-1:0]    exp_q[$];
  logic [N_REQ-1:0] done_exp_q[$];

  uart_tx_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .rd_data    (rd_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .byte_rd    (byte_rd),
    .byte_idx   (byte_idx),
    .done       (done),
    .write_data (write_data),
    .write_en   (write_en),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input int r, input int j);
    if (r == 1) return 8'(8'h41 + j);
    return 8'(8'h80 + r * 16 + j);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int r);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic push_bytes(input int r, input int nbytes);
    for (int j = 0; j < nbytes; j++) exp_q.push_back({onehot(r), byte_val(r, j)});
  endtask

  task automatic push_pkt(input int r, input int nbytes);
    push_bytes(r, nbytes);
    done_exp_q.push_back(onehot(r));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (done == '0 && k < budget);
    check(tag, 32'(done != '0), 1);
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_wr < target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, n_wr, target);
  endtask

  // Monitor and scoreboard first, then the source and UART models update.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (write_en) begin
      n_wr++;
      check("busy_at_send", 32'(tx_busy), 0);
      if (exp_q.size() == 0) begin
        check("write_unexpected", 32'(write_en), 0);
      end else begin
        e = exp_q.pop_front();
        check("write_byte", 32'({grant, write_data}), 32'(e));
      end
    end
    if (byte_rd != '0) begin
      n_rd++;
      check("byte_rd_owner", 32'(byte_rd), 32'(grant));
    end
    if (done != '0) begin
      n_done++;
      check("grant_at_done", 32'(grant), 0);
      if (done_exp_q.size() == 0) check("done_unexpected", 32'(done), 0);
      else check("done_vec", 32'(done), 32'(done_exp_q.pop_front()));
    end
    for (int i = 0; i < N_REQ; i++)
      if (byte_rd[i]) rd_data[i*8 +: 8] = byte_val(i, int'(byte_idx));
    if (write_en && uart_en) begin
      tx_busy  = 1'b1;
      busy_cnt = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
  end

  initial begin
    int base_wr;
    int base_rd;
    int k;

    // Reset
    rst_n   = 1'b0;
    req     = '0;
    req_len = '0;
    uart_en = 1'b1;
    tick(3);
    check("rst_grant", 32'(grant), 0);
    check("rst_byte_rd", 32'(byte_rd), 0);
    check("rst_byte_idx", 32'(byte_idx), 0);
    check("rst_done", 32'(done), 0);
    check("rst_write_data", 32'(write_data), 0);
    check("rst_write_en", 32'(write_en), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick(2);

    // Round-robin with all four requesting continuously, one byte each
    base_wr = n_wr;
    req_len = {8'd1, 8'd1, 8'd1, 8'd1};
    req     = 4'b1111;
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1); push_pkt(0, 1);
    for (int p = 0; p < 5; p++) wait_done("rr_done", 200);
    req = '0;
    check("rr_bytes", n_wr - base_wr, 5);
    tick(3);

    // Single packet with latency checks
    base_wr = n_wr;
    req_len = '0;
    req_len[1*LEN_W +: LEN_W] = 8'd3;
    req[1]  = 1'b1;
    push_pkt(1, 3);
    tick(1);
    check("lat_grant", 32'(grant), 32'(4'b0010));
    check("lat_byte_rd", 32'(byte_rd), 32'(4'b0010));
    check("lat_byte_idx", 32'(byte_idx), 0);
    check("lat_fetch", 32'(dbg_state), 32'(FETCH));
    tick(1);
    check("lat_capture", 32'(dbg_state), 32'(CAPTURE));
    check("lat_rd_once", 32'(byte_rd), 0);
    tick(1);
    check("lat_write_en", 32'(write_en), 1);
    check("lat_write_data", 32'(write_data), 32'h41);
    wait_done("single_done", 300);
    req = '0;
    check("single_bytes", n_wr - base_wr, 3);
    tick(1);
    check("single_done_pulse", 32'(done), 0);
    tick(2);

    // Zero length packet
    base_wr = n_wr;
    base_rd = n_rd;
    req_len = '0;
    req[2]  = 1'b1;
    push_pkt(2, 0);
    tick(1);
    check("zero_state", 32'(dbg_state), 32'(DONE));
    check("zero_grant", 32'(grant), 32'(4'b0100));
    check("zero_done_early", 32'(done), 0);
    tick(1);
    check("zero_done", 32'(done), 32'(4'b0100));
    req = '0;
    tick(3);
    check("zero_no_write", n_wr - base_wr, 0);
    check("zero_no_read", n_rd - base_rd, 0);

    // Request dropped after the first byte
    base_wr = n_wr;
    req_len[0 +: LEN_W] = 8'd4;
    req[0] = 1'b1;
    push_pkt(0, 4);
    wait_wr("drop_first", base_wr + 1, 100);
    req[0] = 1'b0;
    wait_done("drop_done", 400);
    check("drop_bytes", n_wr - base_wr, 4);
    tick(3);

    // Reset during the wait for the second byte
    base_wr = n_wr;
    req_len[1*LEN_W +: LEN_W] = 8'd3;
    req[1] = 1'b1;
    push_bytes(1, 2);
    wait_wr("rstmid_bytes", base_wr + 2, 200);
    tick(5);
    check("rstmid_pre_state", 32'(dbg_state), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check("rstmid_grant", 32'(grant), 0);
    check("rstmid_byte_idx", 32'(byte_idx), 0);
    check("rstmid_write_data", 32'(write_data), 0);
    check("rstmid_write_en", 32'(write_en), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    req = '0;
    k = 0;
    while (tx_busy && k < 50) begin
      tick(1);
      k++;
    end
    check("rstmid_uart_idle", 32'(tx_busy), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    req_len = {8'd0, 8'd0, 8'd1, 8'd1};
    req     = 4'b0011;
    push_pkt(0, 1);
    push_pkt(1, 1);
    tick(1);
    check("rstmid_prio", 32'(grant), 32'(4'b0001));
    wait_done("rstmid_done0", 200);
    wait_done("rstmid_done1", 200);
    req = '0;
    tick(3);

    // UART never goes busy: one send, then parked in WAIT
    base_wr = n_wr;
    uart_en = 1'b0;
    req_len[3*LEN_W +: LEN_W] = 8'd2;
    req[3] = 1'b1;
    push_bytes(3, 1);
    tick(60);
    check("glitch_one_send", n_wr - base_wr, 1);
    check("glitch_state", 32'(dbg_state), 32'(WAIT));
    check("glitch_grant", 32'(grant), 32'(4'b1000));
    check("glitch_idx", 32'(byte_idx), 0);
    rst_n = 1'b0;
    req   = '0;
    tick(2);
    rst_n   = 1'b1;
    uart_en = 1'b1;
    tick(3);

    check("sb_bytes_left", exp_q.size(), 0);
    check("sb_done_left", done_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (byte-wide write_data/write_en input, tx_busy status output) between N_REQ independent packet sources, e.g. status reporter, register read-back and debug dump. Each requester raises a request with a byte count. The arbiter grants in round-robin order and fetches bytes from the granted source through a 1-cycle-latency read port. It paces each byte on the transmitter's tx_busy falling edge and pulses done when the packet completes. It sits between the byte-generating blocks and the UART TX core.

## Interface
- N_REQ, 4: number of requesters (2..8)
- LEN_W, 8: width of packet length and byte index
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester packet request, level, held until matching done
- req_len  in  N_REQ*LEN_W  packet byte count per requester, slice i = bits [i*LEN_W +: LEN_W], sampled at grant
- rd_data  in  N_REQ*8  byte from each requester, valid 1 cycle after its byte_rd
- tx_busy  in  1  UART TX busy, high while a byte is shifting out
- grant  out  N_REQ  one-hot owner of the transmitter, 0 when idle
- byte_rd  out  N_REQ  one-hot 1-cycle read strobe to the granted requester
- byte_idx  out  LEN_W  index of the byte being read, valid with byte_rd
- done  out  N_REQ  one-hot 1-cycle packet-complete pulse
- write_data  out  8  byte to UART TX
- write_en  out  1  1-cycle transmit strobe to UART TX

## Operation
- States: IDLE, FETCH, CAPTURE, SEND, WAIT, DONE.
- IDLE: if req != 0, the round-robin pick selects a winner. Search starts at (last_winner+1) mod N_REQ. After reset last_winner = N_REQ-1, so requester 0 has first priority. Latch grant, latch len = req_len slice, byte_idx=0, go to FETCH.
- Zero length: if the latched len == 0, go directly to DONE. No byte_rd and no write_en are issued.
- FETCH: byte_rd[winner]=1 for one cycle, then CAPTURE.
- CAPTURE: write_data <= rd_data slice of the winner, then SEND.
- SEND: write_en=1 for one cycle, then WAIT.
- WAIT: hold until a tx_busy falling edge (tx_busy_d & ~tx_busy, with tx_busy_d registered). Edge detection is enabled only in WAIT.
  - If byte_idx == len-1: go to DONE.
  - Else: byte_idx <= byte_idx+1, go to FETCH.
- DONE: done[winner]=1 for one cycle, last_winner <= winner, grant <= 0, go to IDLE.
- A packet is never pre-empted. Deasserting req mid-packet has no effect, and the packet runs to len bytes.
- Changes to req_len after grant are ignored.
- A requester still holding req in the IDLE cycle after DONE is eligible again, but only behind the other pending requesters in round-robin order.
- The byte_idx wrap is impossible, because len ≤ 2^LEN_W-1.

## Timing
- Reset values: grant=0, byte_rd=0, byte_idx=0, done=0, write_data=8'h00, write_en=0, state=IDLE, last_winner=N_REQ-1, tx_busy_d=0.
- Reset is asynchronous and is honoured in any state. Reset mid-packet abandons the packet with no done pulse. The UART core finishes whatever byte it already holds.
- All outputs are registered.
- Latency per packet (req seen in IDLE at cycle 0):
  - cycle 1: grant and byte_rd valid
  - cycle 2: CAPTURE
  - cycle 3: write_en high with write_data stable
- write_data holds until the next CAPTURE.
- Between bytes: from the cycle after the tx_busy falling edge is registered, the next write_en follows 3 cycles later (FETCH, CAPTURE, SEND).
- Minimum gap between packets: DONE plus 1 IDLE cycle.
- tx_busy falling in the same cycle as DONE/IDLE is ignored.

## Structure
- Package uart_tx_arb_pkg:
  - state enum (IDLE=0 … DONE=5, 3-bit)
  - default N_REQ/LEN_W constants
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, last_winner.
  - Outputs: one-hot winner and index.
  - Reused by other shared resources in the design.
- Top: FSM, length/index counters, tx_busy edge register, output registers.

## Test plan
- Single packet: req[1]=1, len=3, rd_data bytes 8'h41/8'h42/8'h43. UART model holds busy 20 cycles per byte.
  - Required: three write_en pulses carrying 41, 42, 43, each issued after the previous busy fall.
  - Required: done[1] is a single pulse after the third busy fall.
- Round-robin: req=4'b1111 held continuously, len=1 each. Required: grant order 0,1,2,3,0. No requester is granted twice while others wait.
- Zero length: req[2]=1, len=0. Required: done[2] pulses at cycle 2 after req. byte_rd and write_en never assert.
- Req drop mid-packet: req[0] is deasserted after the first byte of len=4. Required: all 4 bytes are sent, then done[0].
- Reset mid-packet: rst_n is pulled low during WAIT of byte 2. Required: all outputs return to their reset values immediately, with no done pulse. After release, requester 0 has first priority again.
- Glitch immunity: tx_busy is held low (UART never accepts). Required: FSM stays in WAIT with a single write_en pulse and no spurious re-send.
